// File: rtl/desp_iterativo.sv
// ---------------------------------------------------------------------------
// desp_iterativo
//
// Iterative barrel shifter. A request loads the operand into a working
// register and the shift amount into a remaining-count register. The block
// then shifts by at most PASO positions per clock until the count reaches
// zero. On the following edge it copies the working register to Y and
// pulses valido.
//
// Modes (modo): 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
//
// Handshake: a request is taken on a rising edge where rst=0, inicio=1 and
// ocupado=0. While ocupado=1, inicio is ignored. valido is high for exactly
// one cycle, which is the first cycle in which Y shows the new result.
// ocupado is already low in that cycle, so a request can be issued then to
// get back-to-back operation.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous, active-high reset
//   inicio   in   1      request strobe
//   a        in   ANCHO  operand, sampled on acceptance
//   b        in   SW     shift amount (unsigned), sampled on acceptance
//   modo     in   2      shift mode, sampled on acceptance
//   Y        out  ANCHO  last completed result
//   valido   out  1      one-cycle pulse when Y first shows a new result
//   ocupado  out  1      operation in progress
//
// The FSM state is held in estado_q (REPOSO/DESPLAZA). The remaining count
// is held in restante_q. Together these expose the progress of a running
// operation.
// ---------------------------------------------------------------------------
module desp_iterativo #(
    parameter int ANCHO = 32,
    parameter int PASO  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inicio,
    input  logic [ANCHO-1:0]           a,
    input  logic [$clog2(ANCHO)-1:0]   b,
    input  logic [1:0]                 modo,
    output logic [ANCHO-1:0]           Y,
    output logic                       valido,
    output logic                       ocupado
);

    localparam int SW = $clog2(ANCHO);

    // One extra bit so that both PASO and ANCHO fit in the value
    // (PASO may be equal to ANCHO).
    localparam logic [SW:0] PASO_L  = (SW+1)'(PASO);
    localparam logic [SW:0] ANCHO_L = (SW+1)'(ANCHO);

    localparam logic [1:0] MODO_SLL = 2'b00;
    localparam logic [1:0] MODO_SRL = 2'b01;
    localparam logic [1:0] MODO_SRA = 2'b10;
    localparam logic [1:0] MODO_ROR = 2'b11;

    typedef enum logic {
        REPOSO   = 1'b0,
        DESPLAZA = 1'b1
    } estado_t;

    estado_t            estado_q,   estado_d;
    logic [ANCHO-1:0]   trabajo_q,  trabajo_d;
    logic [SW-1:0]      restante_q, restante_d;
    logic [1:0]         modo_q,     modo_d;
    logic [ANCHO-1:0]   y_q,        y_d;
    logic               valido_q,   valido_d;
    logic               ocupado_q,  ocupado_d;

    // Step size for this edge: k = min(r, PASO).
    logic [SW:0]        paso_k;
    logic [ANCHO-1:0]   desplazado;

    always_comb begin
        paso_k = {1'b0, restante_q};
        if ({1'b0, restante_q} > PASO_L) begin
            paso_k = PASO_L;
        end
    end

    // One step of the shift. The step happens only while r>0, so paso_k is
    // between 1 and ANCHO-1. For ROR this keeps the left-shift amount
    // (ANCHO-k) in range and never zero.
    always_comb begin
        desplazado = trabajo_q;
        case (modo_q)
            MODO_SLL: desplazado = trabajo_q << paso_k;
            MODO_SRL: desplazado = trabajo_q >> paso_k;
            MODO_SRA: desplazado = $signed(trabajo_q) >>> paso_k;
            MODO_ROR: desplazado = (trabajo_q >> paso_k)
                                 | (trabajo_q << (ANCHO_L - paso_k));
            default:  desplazado = trabajo_q;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        estado_d   = estado_q;
        trabajo_d  = trabajo_q;
        restante_d = restante_q;
        modo_d     = modo_q;
        y_d        = y_q;
        valido_d   = 1'b0;
        ocupado_d  = ocupado_q;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    estado_d   = DESPLAZA;
                    trabajo_d  = a;
                    restante_d = b;
                    modo_d     = modo;
                    ocupado_d  = 1'b1;
                end
            end

            DESPLAZA: begin
                if (restante_q != '0) begin
                    trabajo_d  = desplazado;
                    restante_d = restante_q - paso_k[SW-1:0];
                end else begin
                    // Completion edge: publish the result and release the
                    // block. A request in the valido cycle is then seen by
                    // REPOSO.
                    y_d       = trabajo_q;
                    valido_d  = 1'b1;
                    ocupado_d = 1'b0;
                    estado_d  = REPOSO;
                end
            end

            default: begin
                estado_d  = REPOSO;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // Reset clears everything, including the working register. An aborted
    // operation therefore can never reach Y.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= REPOSO;
            trabajo_q  <= '0;
            restante_q <= '0;
            modo_q     <= '0;
            y_q        <= '0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            trabajo_q  <= trabajo_d;
            restante_q <= restante_d;
            modo_q     <= modo_d;
            y_q        <= y_d;
            valido_q   <= valido_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign Y       = y_q;
    assign valido  = valido_q;
    assign ocupado = ocupado_q;

endmodule

// File: tb/tb_desp_iterativo.sv
// Bench for desp_iterativo. Three instances with PASO = 1, 4 and 32 share
// the same stimulus. Each one has its own expected queue, because its
// latency differs.
module tb_desp_iterativo;

  localparam int ANCHO = 32;
  localparam int SW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              inicio;
  logic [ANCHO-1:0]  a;
  logic [SW-1:0]     b;
  logic [1:0]        modo;

  logic [ANCHO-1:0]  y_w       [3];
  logic              valido_w  [3];
  logic              ocupado_w [3];

  desp_iterativo #(.ANCHO(ANCHO), .PASO(1)) u_p1 (
    .clk(clk), .rst(rst), .inicio(inicio), .a(a), .b(b), .modo(modo),
    .Y(y_w[0]), .valido(valido_w[0]), .ocupado(ocupado_w[0])
  );

  desp_iterativo #(.ANCHO(ANCHO), .PASO(4)) u_p4 (
    .clk(clk), .rst(rst), .inicio(inicio), .a(a), .b(b), .modo(modo),
    .Y(y_w[1]), .valido(valido_w[1]), .ocupado(ocupado_w[1])
  );

  desp_iterativo #(.ANCHO(ANCHO), .PASO(32)) u_p32 (
    .clk(clk), .rst(rst), .inicio(inicio), .a(a), .b(b), .modo(modo),
    .Y(y_w[2]), .valido(valido_w[2]), .ocupado(ocupado_w[2])
  );

  int ciclo = 0;
  always @(posedge clk) ciclo <= ciclo + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [ANCHO-1:0] y;
    int               b;
    int               acc;  // cycle count right after the acceptance edge
  } exp_t;

  exp_t             exp_q0 [$];
  exp_t             exp_q1 [$];
  exp_t             exp_q2 [$];
  logic [ANCHO-1:0] exp_y  [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [ANCHO-1:0] got,
                       input logic [ANCHO-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, ciclo);
    end
  endtask

  function automatic logic [ANCHO-1:0] ref_shift(input logic [ANCHO-1:0] x,
                                                 input int sh, input logic [1:0] m);
    logic signed [ANCHO-1:0] s;
    s = x;
    case (m)
      2'b00:   return x << sh;
      2'b01:   return x >> sh;
      2'b10:   return s >>> sh;
      default: return (sh == 0) ? x : ((x >> sh) | (x << (ANCHO - sh)));
    endcase
  endfunction

  function automatic int paso_de(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic int latencia(input int bb, input int p);
    return (bb + p - 1) / p + 1;
  endfunction

  function automatic int pendientes();
    return exp_q0.size() + exp_q1.size() + exp_q2.size();
  endfunction

  function automatic void push_exp(input logic [ANCHO-1:0] aa, input int bb,
                                   input logic [1:0] mm);
    exp_t e;
    e.y   = ref_shift(aa, bb, mm);
    e.b   = bb;
    e.acc = ciclo + 1;
    exp_q0.push_back(e);
    exp_q1.push_back(e);
    exp_q2.push_back(e);
  endfunction

  function automatic void vaciar();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endfunction

  // Per-cycle comparison for one instance: valido, ocupado and Y.
  task automatic vigilar(input int i, input logic [ANCHO-1:0] y_obs,
                         input logic v_obs, input logic o_obs);
    exp_t tmp [$];
    logic exp_v;
    logic exp_o;
    int   p;
    int   lat;
    p = paso_de(i);
    case (i)
      0:       tmp = exp_q0;
      1:       tmp = exp_q1;
      default: tmp = exp_q2;
    endcase
    exp_v = 1'b0;
    exp_o = 1'b0;
    foreach (tmp[j]) begin
      lat = latencia(tmp[j].b, p);
      if (ciclo >= tmp[j].acc && ciclo < tmp[j].acc + lat) exp_o = 1'b1;
    end
    if (tmp.size() > 0) begin
      lat = latencia(tmp[0].b, p);
      if (ciclo == tmp[0].acc + lat) begin
        exp_v   = 1'b1;
        exp_y[i] = tmp[0].y;
        case (i)
          0:       void'(exp_q0.pop_front());
          1:       void'(exp_q1.pop_front());
          default: void'(exp_q2.pop_front());
        endcase
      end
    end
    check($sformatf("p%0d_valido", p),  {31'b0, v_obs}, {31'b0, exp_v});
    check($sformatf("p%0d_ocupado", p), {31'b0, o_obs}, {31'b0, exp_o});
    check($sformatf("p%0d_Y", p),       y_obs,          exp_y[i]);
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) vigilar(i, y_w[i], valido_w[i], ocupado_w[i]);
  end

  // ---------------- driver tasks ----------------
  task automatic lanzar(input logic [ANCHO-1:0] aa, input int bb, input logic [1:0] mm);
    @(negedge clk);
    inicio = 1'b1;
    a      = aa;
    b      = bb[SW-1:0];
    modo   = mm;
    push_exp(aa, bb, mm);
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic esperar_fin();
    int n;
    n = 0;
    while (pendientes() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (pendientes() > 0) begin
      check("timeout_pendientes", pendientes(), 0);
      vaciar();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) exp_y[i] = '0;
    // A request held during reset must be dropped.
    rst    = 1'b1;
    inicio = 1'b1;
    a      = 32'hDEAD_BEEF;
    b      = 5'd3;
    modo   = 2'b00;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    inicio = 1'b0;
    repeat (2) @(negedge clk);

    // b = 0 in every mode: Y = a, latency 1.
    for (int m = 0; m < 4; m++) begin
      lanzar(32'hA5C3_0F17 ^ 32'(m), 0, 2'(m));
      esperar_fin();
    end

    // Fixed cases for SLL and ROR.
    lanzar(32'h0000_0001, 4, 2'b00);
    esperar_fin();
    lanzar(32'h0000_0001, 1, 2'b11);
    esperar_fin();

    // Sweep of 0x80000000 for SRL and then SRA, b = 0..31.
    for (int m = 1; m <= 2; m++) begin
      for (int sh = 0; sh < ANCHO; sh++) begin
        lanzar(32'h8000_0000, sh, 2'(m));
        esperar_fin();
      end
    end

    // inicio in the second cycle of a b=20 operation must be ignored.
    lanzar(32'hC000_0003, 20, 2'b10);
    @(negedge clk);
    inicio = 1'b1;
    a      = 32'h0F0F_0F0F;
    b      = 5'd5;
    modo   = 2'b00;
    @(negedge clk);
    inicio = 1'b0;
    esperar_fin();
    repeat (10) @(negedge clk);

    // Back-to-back: second request in the valido cycle of the first.
    lanzar(32'h0000_00F0, 1, 2'b00);
    @(negedge clk);
    lanzar(32'h1234_5678, 7, 2'b11);
    esperar_fin();

    // Reset in the middle of a b=31 SRA, then a request on the first free edge.
    lanzar(32'h8000_0000, 31, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    vaciar();
    for (int i = 0; i < 3; i++) exp_y[i] = '0;
    @(negedge clk);
    rst    = 1'b0;
    inicio = 1'b1;
    a      = 32'h0000_0F00;
    b      = 5'd6;
    modo   = 2'b01;
    push_exp(32'h0000_0F00, 6, 2'b01);
    @(negedge clk);
    inicio = 1'b0;
    esperar_fin();

    // Random operations over all modes and amounts.
    for (int n = 0; n < 30; n++) begin
      lanzar($urandom(), $urandom_range(0, ANCHO - 1), 2'($urandom_range(0, 3)));
      esperar_fin();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
